uart_rx_oversample: RTL and testbench

- UART receiver stage sitting directly downstream of the sampling-tick generator.
- Consumes the 1-cycle s_tick strobe (OVERSAMPLE ticks per bit) and deserialises the asynchronous rx line: 8N1 by default, LSB first.
- Uses 3-sample majority voting at mid-bit, and validates both the start bit and the stop bit.
- Delivers each byte with a 1-cycle done strobe to the downstream decoder.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_vote.sv | 38 +++
 rtl/uart_rx_oversample.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the oversampling UART receiver: state encoding,
// default oversampling ratio and the placement of the mid-bit vote ticks.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 32;

  // Vote window is centred on tick OVERSAMPLE/2; samples taken one tick either side.
  localparam int VOTE_PRE  = 1;
  localparam int VOTE_POST = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Mid-bit 3-sample majority voter. The first two samples are held in flops;
// the third is the live line value on the deciding tick.
module uart_rx_vote
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  localparam int SW = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_tick_i,
  input  logic [SW-1:0] s_i,
  input  logic          rx_s_i,
  output logic          vote_valid_o,
  output logic          vote_bit_o
);

  localparam logic [SW-1:0] TICK_A = SW'(OVERSAMPLE / 2 - VOTE_PRE);
  localparam logic [SW-1:0] TICK_B = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] TICK_C = SW'(OVERSAMPLE / 2 + VOTE_POST);

  logic samp_a_q;
  logic samp_b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else if (s_tick_i) begin
      if (s_i == TICK_A) samp_a_q <= rx_s_i;
      if (s_i == TICK_B) samp_b_q <= rx_s_i;
    end
  end

  assign vote_valid_o = s_tick_i && (s_i == TICK_C);
  assign vote_bit_o   = maj3(samp_a_q, samp_b_q, rx_s_i);

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1 default, LSB first) with start/stop
// validation. Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] LAST_S = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] LAST_N = NW'(DBIT - 1);

  logic            rx_meta_q, rx_s_q;
  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            busy_q;
  logic            vote_valid, vote_bit;
  logic            tick_last;

`ifdef UART_RX_PARITY_EN
  logic perr_lat_q, perr_lat_d;
  logic perr_q, perr_d;
`endif

  uart_rx_vote #(.OVERSAMPLE(OVERSAMPLE)) u_vote (
    .clk         (clk),
    .reset       (reset),
    .s_tick_i    (s_tick),
    .s_i         (s_q),
    .rx_s_i      (rx_s_q),
    .vote_valid_o(vote_valid),
    .vote_bit_o  (vote_bit)
  );

  assign tick_last = s_tick && (s_q == LAST_S);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_lat_d = perr_lat_q;
    perr_d     = 1'b0;
`endif
    // The tick counter free-runs in every non-idle state and wraps each bit period.
    if (state_q != ST_IDLE && s_tick) s_d = (s_q == LAST_S) ? '0 : s_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          s_d     = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (vote_valid && vote_bit) state_d = ST_IDLE;
        else if (tick_last) begin
          n_d     = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (vote_valid) sh_d = {vote_bit, sh_q[DBIT-1:1]};
        if (tick_last) begin
          if (n_q == LAST_N) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (vote_valid) perr_lat_d = vote_bit ^ (^sh_q) ^ 1'(PARITY_ODD);
        if (tick_last) state_d = ST_STOP;
      end
`endif
      // Finish at the stop-bit vote so a following start edge is never missed.
      ST_STOP: begin
        if (vote_valid) begin
          dout_d  = sh_q;
          done_d  = 1'b1;
          ferr_d  = ~vote_bit;
`ifdef UART_RX_PARITY_EN
          perr_d  = perr_lat_q;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      sh_q      <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      // Registered from the current state: still high alongside the done pulse.
      busy_q    <= (state_q != ST_IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_lat_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      perr_lat_q <= perr_lat_d;
      perr_q     <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = ^PARITY_ODD;
  assign parity_err = 1'b0;
`endif

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed + randomized bench for uart_rx_oversample: frames are built from the
// UART framing rules and compared against an expected-frame queue.
module tb_uart_rx_oversample;

  localparam int DBIT       = 8;
  localparam int OVERSAMPLE = 32;
  localparam int PARITY_ODD = 0;
  localparam int BIT_CLKS   = OVERSAMPLE * 2;
  localparam int W          = DBIT + 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            s_tick = 1'b0;
  logic            rx = 1'b1;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick, frame_err, parity_err, rx_busy;

  int tests_run = 0;
  int tests_failed = 0;
  int stray_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic busy_at_done = 1'b0;
  logic busy_after   = 1'b1;
  logic prev_done    = 1'b0;

  uart_rx_oversample #(.DBIT(DBIT), .OVERSAMPLE(OVERSAMPLE), .PARITY_ODD(PARITY_ODD)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .rx_dout     (rx_dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .rx_busy     (rx_busy)
  );

  // clock / tick generation (one tick every 2 clk)
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk) s_tick = 1'b1;
      @(negedge clk) s_tick = 1'b0;
    end
  end

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (prev_done) busy_after = rx_busy;
    if (rx_done_tick) begin
      obs_q.push_back({parity_err, frame_err, rx_dout});
      busy_at_done = rx_busy;
    end
    if ((frame_err || parity_err) && !rx_done_tick) stray_err++;
    prev_done = rx_done_tick;
  end

  // driver tasks
  task automatic send_bit(input logic b, input int glitch_at);
    for (int c = 0; c < BIT_CLKS; c++) begin
      if (glitch_at >= 0 && (c == glitch_at || c == glitch_at + 1)) rx = ~b;
      else rx = b;
      @(negedge clk);
    end
    rx = b;
  endtask

  task automatic send_frame(input logic [DBIT-1:0] data, input logic par, input logic stop,
                            input int gbit, input int goff);
    send_bit(1'b0, -1);
    for (int i = 0; i < DBIT; i++) send_bit(data[i], (i == gbit) ? goff : -1);
`ifdef UART_RX_PARITY_EN
    send_bit(par, -1);
`endif
    send_bit(stop, -1);
  endtask

  task automatic idle_bits(input int nbits);
    rx = 1'b1;
    repeat (nbits * BIT_CLKS) @(negedge clk);
  endtask

  // reference model: what a correctly framed receiver must report for one frame
  function automatic logic [W-1:0] model(input logic [DBIT-1:0] data, input logic par,
                                         input logic stop);
    logic perr;
`ifdef UART_RX_PARITY_EN
    perr = (par != ((^data) ^ 1'(PARITY_ODD)));
`else
    perr = 1'b0;
`endif
    return {perr, ~stop, data};
  endfunction

  // scoreboard helpers
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 4 * BIT_CLKS && obs_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) chk(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DBIT-1:0] d;
    logic            p, st;
    int              gb, go;

    // reset state
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dout", 32'(rx_dout), 0);
    chk("rst_done", 32'(rx_done_tick), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_busy", 32'(rx_busy), 0);
    reset = 1'b0;
    idle_bits(1);

    // 1: clean frame 0xA5
    exp_q.push_back(model(8'hA5, ^8'hA5, 1'b1));
    send_frame(8'hA5, ^8'hA5, 1'b1, -1, 0);
    wait_frames(1);
    chk("t1_busy_at_done", 32'(busy_at_done), 1);
    chk("t1_busy_after", 32'(busy_after), 0);
    check_frames("t1_frame");
    idle_bits(1);

    // 2: false start, line low for 10 ticks only
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("t2_no_done", obs_q.size(), 0);
    chk("t2_busy", 32'(rx_busy), 0);
    chk("t2_dout_hold", 32'(rx_dout), 32'h A5);
    obs_q.delete();

    // 3: stop bit driven low
    exp_q.push_back(model(8'h3C, ^8'h3C, 1'b0));
    send_frame(8'h3C, ^8'h3C, 1'b0, -1, 0);
    wait_frames(1);
    idle_bits(2);
    check_frames("t3_frame_err");

    // 4: single-tick glitch at centre of bit 3
    exp_q.push_back(model(8'h55, ^8'h55, 1'b1));
    send_frame(8'h55, ^8'h55, 1'b1, 3, BIT_CLKS / 2);
    wait_frames(1);
    check_frames("t4_glitch");
    idle_bits(1);

    // 5: back-to-back 0x00, 0xFF, then reset during bit 4 of a third frame
    exp_q.push_back(model(8'h00, 1'b0, 1'b1));
    exp_q.push_back(model(8'hFF, 1'b0, 1'b1));
    send_frame(8'h00, 1'b0, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, -1, 0);
    send_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, -1);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    wait_frames(2);
    check_frames("t5_b2b");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_dout", 32'(rx_dout), 0);
    chk("t5_rst_done", 32'(rx_done_tick), 0);
    chk("t5_rst_ferr", 32'(frame_err), 0);
    chk("t5_rst_perr", 32'(parity_err), 0);
    chk("t5_rst_busy", 32'(rx_busy), 0);
    idle_bits(12);
    chk("t5_no_third", obs_q.size(), 0);
    obs_q.delete();

`ifdef UART_RX_PARITY_EN
    // 6: even parity on 0x07
    exp_q.push_back(model(8'h07, 1'b1, 1'b1));
    send_frame(8'h07, 1'b1, 1'b1, -1, 0);
    wait_frames(1);
    check_frames("t6_par_ok");
    idle_bits(1);
    exp_q.push_back(model(8'h07, 1'b0, 1'b1));
    send_frame(8'h07, 1'b0, 1'b1, -1, 0);
    wait_frames(1);
    check_frames("t6_par_bad");
    idle_bits(1);
`endif

    // randomized frames: data, stop bit, parity bit, glitch placement, idle gap
    for (int k = 0; k < 16; k++) begin
      d  = DBIT'($urandom_range(0, (1 << DBIT) - 1));
      st = ($urandom_range(0, 3) != 0);
      p  = 1'($urandom_range(0, 1));
      gb = int'($urandom_range(0, DBIT)) - 1;
      go = int'($urandom_range(12, 50));
      exp_q.push_back(model(d, p, st));
      send_frame(d, p, st, gb, go);
      wait_frames(1);
      check_frames("rand_frame");
      idle_bits(st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
    end
    idle_bits(2);
    chk("stray_err_pulses", 32'(stray_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
